// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the core data port and a word-wide data RAM.
// Byte/halfword/word loads are lane-selected and sign/zero extended, sub-word
// stores are done as read-modify-write, and misaligned or illegal accesses are
// answered with ACK+ERR without touching the RAM.
module dmem_lsu #(
  parameter int RAM_DATA = 32,
  parameter int RAM_ADD  = 10
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                REQ,
  input  logic                WE,
  input  logic [2:0]          FUNCT3,
  input  logic [31:0]         ADDR,
  input  logic [31:0]         WDATA,
  output logic [31:0]         RDATA,
  output logic                ACK,
  output logic                ERR,
  output logic [RAM_ADD-1:0]  DIR_DMEM,
  output logic [RAM_DATA-1:0] DATA_WRITE_DMEM,
  input  logic [RAM_DATA-1:0] DATA_READ_DMEM,
  output logic                READ,
  output logic                WRITE
);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_CAPT, RMW_ISSUE, RMW_MERGE, WR, DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [RAM_ADD+1:0]  addr_reg;
  logic [31:0]         wdata_reg;
  logic [2:0]          funct3_reg;
  logic                err_reg;
  logic [31:0]         rdata_reg;
  logic [RAM_DATA-1:0] wr_data_reg;

  logic                f3_legal;
  logic                req_err;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [31:0]         load_ext;
  logic [RAM_DATA-1:0] merged;

  // Address bits above the RAM range are deliberately dropped (address wraps).
  logic unused_addr_bits;
  assign unused_addr_bits = ^ADDR[31:RAM_ADD+2];

  // Request classification, evaluated on the live inputs in the accept cycle.
  assign f3_legal = (FUNCT3 == 3'b000) || (FUNCT3 == 3'b001) || (FUNCT3 == 3'b010) ||
                    (FUNCT3 == 3'b100) || (FUNCT3 == 3'b101);
  assign req_err  = !f3_legal ||
                    ((FUNCT3[1:0] == 2'b01) && ADDR[0]) ||
                    ((FUNCT3 == 3'b010) && (ADDR[1:0] != 2'b00)) ||
                    (WE && FUNCT3[2]);

  // Lane selection and extension of the word coming back from the RAM.
  always_comb begin
    case (addr_reg[1:0])
      2'b00:   rd_byte = DATA_READ_DMEM[7:0];
      2'b01:   rd_byte = DATA_READ_DMEM[15:8];
      2'b10:   rd_byte = DATA_READ_DMEM[23:16];
      default: rd_byte = DATA_READ_DMEM[31:24];
    endcase
    rd_half = addr_reg[1] ? DATA_READ_DMEM[31:16] : DATA_READ_DMEM[15:0];
    case (funct3_reg)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_ext = {24'b0, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_ext = {16'b0, rd_half};
      default: load_ext = DATA_READ_DMEM;
    endcase
  end

  // Sub-word store merge: replace only the addressed lane of the old word.
  always_comb begin
    merged = DATA_READ_DMEM;
    if (funct3_reg[1:0] == 2'b00) begin
      case (addr_reg[1:0])
        2'b00:   merged[7:0]   = wdata_reg[7:0];
        2'b01:   merged[15:8]  = wdata_reg[7:0];
        2'b10:   merged[23:16] = wdata_reg[7:0];
        default: merged[31:24] = wdata_reg[7:0];
      endcase
    end else if (addr_reg[1]) begin
      merged[31:16] = wdata_reg[15:0];
    end else begin
      merged[15:0] = wdata_reg[15:0];
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic; REQ is only looked at while idle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (REQ) begin
          if (req_err)                state_next = DONE;
          else if (!WE)               state_next = RD_ISSUE;
          else if (FUNCT3 == 3'b010)  state_next = WR;
          else                        state_next = RMW_ISSUE;
        end
      end
      RD_ISSUE:  state_next = RD_CAPT;
      RD_CAPT:   state_next = DONE;
      RMW_ISSUE: state_next = RMW_MERGE;
      RMW_MERGE: state_next = WR;
      WR:        state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Decoded outputs; RAM strobes are forced low while reset is asserted.
  always_comb begin
    READ  = 1'b0;
    WRITE = 1'b0;
    ACK   = 1'b0;
    ERR   = 1'b0;
    case (state_reg)
      RD_ISSUE, RMW_ISSUE: READ  = RESET_N;
      WR:                  WRITE = RESET_N;
      DONE: begin
        ACK = 1'b1;
        ERR = err_reg;
      end
      default: ;
    endcase
  end

  // Request capture, load result and RAM write-data registers.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      addr_reg    <= '0;
      wdata_reg   <= '0;
      funct3_reg  <= '0;
      err_reg     <= 1'b0;
      rdata_reg   <= '0;
      wr_data_reg <= '0;
    end else begin
      if ((state_reg == IDLE) && REQ) begin
        addr_reg    <= ADDR[RAM_ADD+1:0];
        wdata_reg   <= WDATA;
        funct3_reg  <= FUNCT3;
        err_reg     <= req_err;
        wr_data_reg <= WDATA;
      end
      if (state_reg == RD_CAPT)   rdata_reg   <= load_ext;
      if (state_reg == RMW_MERGE) wr_data_reg <= merged;
    end
  end

  assign RDATA           = rdata_reg;
  assign DIR_DMEM        = addr_reg[RAM_ADD+1:2];
  assign DATA_WRITE_DMEM = wr_data_reg;

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit between the CORE data-memory port and the word-wide data RAM.
- Converts core byte/halfword/word accesses into RAM word accesses, with sign/zero extension on loads.
- Sub-word stores use a read-modify-write sequence; misaligned accesses are rejected.
- Handshakes with the core via REQ/ACK so the core stalls for the multi-cycle sequences.

Parameters:
- RAM_DATA, 32, RAM word width; only 32 is supported.
- RAM_ADD, 10, RAM word-address width; RAM holds 2^RAM_ADD words.

Ports:
- CLK  in  1  clock, all state on rising edge
- RESET_N  in  1  synchronous active-low reset
- REQ  in  1  core access request; held with its inputs stable until ACK
- WE  in  1  1 = store, 0 = load
- FUNCT3  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- ADDR  in  32  byte address
- WDATA  in  32  store data, right-aligned
- RDATA  out  32  extended load result, held until the next load ACK
- ACK  out  1  one-cycle completion pulse
- ERR  out  1  high with ACK when the access was rejected
- DIR_DMEM  out  RAM_ADD  RAM word address = captured ADDR[RAM_ADD+1:2]; upper bits ignored (wrap)
- DATA_WRITE_DMEM  out  RAM_DATA  RAM write data
- DATA_READ_DMEM  in  RAM_DATA  RAM read data, valid the cycle after READ was high
- READ  out  1  RAM output enable
- WRITE  out  1  RAM write enable; RAM writes on the CLK edge ending a cycle with WRITE=1

Behaviour:
- Reset: synchronous, RESET_N=0 sampled on the CLK rising edge. State=IDLE; RDATA, ACK, ERR, READ, WRITE, DIR_DMEM and DATA_WRITE_DMEM all 0.
- READ and WRITE are additionally gated low combinationally while RESET_N=0.
- Reset mid-sequence aborts the access: no RAM write occurs, and no ACK is issued for the aborted request.
- States: IDLE, RD_ISSUE, RD_CAPT, RMW_ISSUE, RMW_MERGE, WR, DONE.
- IDLE: REQ is sampled only here. On REQ=1, capture ADDR, WDATA, FUNCT3 and WE, then classify:
  - Error if any of: H/HU with ADDR[0]=1; W with ADDR[1:0]!=00; FUNCT3 outside the legal set; WE=1 with BU/HU.
  - Error -> DONE with ERR=1.
  - Load -> RD_ISSUE.
  - SW -> WR.
  - SB/SH -> RMW_ISSUE.
- RD_ISSUE: READ=1, DIR_DMEM driven; next state RD_CAPT.
- RD_CAPT: sample DATA_READ_DMEM and select the lane by ADDR[1:0]:
  - Byte: lane ADDR[1:0]*8.
  - Half: lane ADDR[1]*16.
  - Word: full word.
  - Sign-extend for B/H, zero-extend for BU/HU; register the result into RDATA; next state DONE.
- RMW_ISSUE: READ=1; next state RMW_MERGE.
- RMW_MERGE: merge WDATA[7:0] or WDATA[15:0] into the selected lane of DATA_READ_DMEM; all other bytes are unchanged; next state WR.
- WR: WRITE=1, DIR_DMEM and DATA_WRITE_DMEM stable (WDATA for SW, merged word for sub-word); next state DONE.
- DONE: ACK=1 for exactly one cycle, ERR as classified; next state IDLE.
  - The core updates on the ACK edge.
  - A REQ seen in the following IDLE cycle is a new access.
- Latency from the REQ-accept cycle to ACK:
  - Error: 1.
  - SW: 2.
  - Load: 3.
  - SB/SH: 4.
- Outputs:
  - READ and WRITE are never high together.
  - WRITE is high for exactly one cycle per store.
  - RDATA is unchanged by stores and by errors.
- Back-to-back accesses: minimum one IDLE cycle between ACK and the next accept.

Test Plan:
- SW ADDR=0x10 WDATA=0xDEADBEEF -> WRITE=1, DIR_DMEM=4 in the cycle after accept; ACK 2 cycles after accept. Then LW 0x10 -> RDATA=0xDEADBEEF, ACK 3 cycles after accept.
- With word 4=0xDEADBEEF: SB ADDR=0x12 WDATA=0x55 -> one READ, then one WRITE of 0xDE55BEEF. LW 0x10 -> 0xDE55BEEF.
- With word 4=0xDE55BEEF:
  - LB 0x13 -> 0xFFFFFFDE.
  - LBU 0x13 -> 0x000000DE.
  - LH 0x10 -> 0xFFFFBEEF.
  - LHU 0x12 -> 0x0000DE55.
- LH ADDR=0x11, LW ADDR=0x12, SB with FUNCT3=100 -> each: ACK+ERR the cycle after accept, READ/WRITE never high, RDATA unchanged.
- SH ADDR=0x20 with RESET_N pulled low in the RMW_MERGE cycle -> WRITE never asserted, no ACK, outputs 0 the next cycle; word 8 unchanged on readback.
- ADDR=0x1000 (beyond 2^RAM_ADD words) SW -> DIR_DMEM=0 (wrap); readback at ADDR=0x0 returns the stored word.
